// File: rtl/four_bit_player_7seg.sv
// Time-multiplexed driver for a 4-digit seven-segment display: scans four hex
// digits round-robin, driving a one-hot digit enable and decoded segments.
module four_bit_player_7seg #(
    parameter int SCAN_DIV    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_0,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    input  logic [3:0] digit_3,
    output logic [6:0] my_display,
    output logic [3:0] my_digit
);

    localparam int CW = $clog2(SCAN_DIV) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = SEG_ACT_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [3:0] DIG_OFF   = DIG_ACT_LOW ? 4'b1111 : 4'b0000;

    // Active-low gfedcba glyphs; anything that is not a clean hex value
    // (including X/Z in simulation) falls through to blank.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    sel_r;
    logic [3:0]    digit_sel_s;
    logic [3:0]    dig_on_s;
    logic [6:0]    seg_on_s;

    // Pick the digit value for the currently selected position.
    always_comb begin
        digit_sel_s = 4'h0;
        case (sel_r)
            2'd0:    digit_sel_s = digit_0;
            2'd1:    digit_sel_s = digit_1;
            2'd2:    digit_sel_s = digit_2;
            2'd3:    digit_sel_s = digit_3;
            default: digit_sel_s = 4'h0;
        endcase
    end

    // Map the active-low glyph and enable onto the configured pin polarity.
    always_comb begin
        dig_on_s = 4'b0001 << sel_r;
        if (DIG_ACT_LOW) begin
            dig_on_s = ~dig_on_s;
        end else begin
            dig_on_s = dig_on_s;
        end
        seg_on_s = hex_to_seg(digit_sel_s);
        if (SEG_ACT_LOW) begin
            seg_on_s = seg_on_s;
        end else begin
            seg_on_s = ~seg_on_s;
        end
    end

    // Prescaler, scan index and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            sel_r      <= 2'd0;
            my_digit   <= DIG_OFF;
            my_display <= SEG_BLANK;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
                sel_r <= sel_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CW'(1);
                sel_r <= sel_r;
            end
            my_digit   <= dig_on_s;
            my_display <= seg_on_s;
        end
    end

    four_bit_player_7seg_chk #(
        .DIG_ACT_LOW(DIG_ACT_LOW)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .my_digit(my_digit)
    );

endmodule

// Checker: once a full cycle has passed out of reset, exactly one digit is enabled.
module four_bit_player_7seg_chk #(
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input logic       clk,
    input logic       rst,
    input logic [3:0] my_digit
);

    logic seen_r;
    logic prev_rst_r;

    // Track whether a reset has happened and whether the last edge was in reset.
    always_ff @(posedge clk) begin
        seen_r     <= seen_r | rst;
        prev_rst_r <= rst;
    end

    a_one_hot: assert property (@(posedge clk)
        (!rst && !prev_rst_r && seen_r) |->
            $onehot(DIG_ACT_LOW ? ~my_digit : my_digit));

endmodule

// File: tb/tb_four_bit_player_7seg.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized run against a position/time model of the scan.
module tb_four_bit_player_7seg;

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } dec_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig [4];
    logic [6:0] disp4, disp1;
    logic [3:0] den4, den1;

    int checks = 0;
    int errors = 0;
    int n4 = 0;
    int n1 = 0;
    dec_vec_t vec [16];

    always #5 clk = ~clk;

    four_bit_player_7seg #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .digit_0(dig[0]), .digit_1(dig[1]), .digit_2(dig[2]), .digit_3(dig[3]),
        .my_display(disp4), .my_digit(den4)
    );

    four_bit_player_7seg #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .digit_0(dig[0]), .digit_1(dig[1]), .digit_2(dig[2]), .digit_3(dig[3]),
        .my_display(disp1), .my_digit(den1)
    );

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; expectations come from the elapsed time since reset
    // release: position = (edges / SCAN_DIV) mod 4, glyph = table[digit].
    task automatic step();
        logic [3:0] one;
        logic [3:0] ed4, ed1;
        logic [6:0] es4, es1;
        int p;
        one = 4'b0001;
        if (rst) begin
            ed4 = 4'b1111; es4 = 7'b1111111;
            ed1 = 4'b1111; es1 = 7'b1111111;
        end else begin
            p   = (n4 / 4) % 4;
            ed4 = ~(one << p);
            es4 = vec[dig[p]].seg;
            p   = n1 % 4;
            ed1 = ~(one << p);
            es1 = vec[dig[p]].seg;
        end
        @(posedge clk);
        #1;
        chk("digit_div4", {3'b000, den4}, {3'b000, ed4});
        chk("display_div4", disp4, es4);
        chk("digit_div1", {3'b000, den1}, {3'b000, ed1});
        chk("display_div1", disp1, es1);
        if (!rst) begin
            checks++;
            if ($countones(~den1) != 1) begin
                errors++;
                $display("FAIL onehot_div1: got %b expected one zero bit", den1);
            end
        end
        if (rst) begin
            n4 = 0;
            n1 = 0;
        end else begin
            n4++;
            n1++;
        end
    endtask

    initial begin
        vec[0]  = '{4'h0, 7'b1000000};
        vec[1]  = '{4'h1, 7'b1111001};
        vec[2]  = '{4'h2, 7'b0100100};
        vec[3]  = '{4'h3, 7'b0110000};
        vec[4]  = '{4'h4, 7'b0011001};
        vec[5]  = '{4'h5, 7'b0010010};
        vec[6]  = '{4'h6, 7'b0000010};
        vec[7]  = '{4'h7, 7'b1111000};
        vec[8]  = '{4'h8, 7'b0000000};
        vec[9]  = '{4'h9, 7'b0010000};
        vec[10] = '{4'hA, 7'b0001000};
        vec[11] = '{4'hB, 7'b0000011};
        vec[12] = '{4'hC, 7'b1000110};
        vec[13] = '{4'hD, 7'b0100001};
        vec[14] = '{4'hE, 7'b0000110};
        vec[15] = '{4'hF, 7'b0001110};

        // Reset, held for several edges with changing inputs.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) dig[k] = 4'($urandom_range(0, 15));
            step();
        end

        // Scan order with digits 0,1,2,3 across more than one full rotation.
        for (int k = 0; k < 4; k++) dig[k] = 4'(k);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Decode sweep on position 0, one cycle after each new value.
        for (int i = 0; i < 16; i++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            dig[0] = vec[i].val;
            step();
            chk("decode_sweep", disp4, vec[i].seg);
            chk("decode_sweep_pos0", {3'b000, den4}, 7'b0001110);
        end

        // Live update of digit 2 while it is displayed.
        rst = 1'b1;
        for (int k = 0; k < 4; k++) dig[k] = 4'(k);
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("live_before", disp4, 7'b0100100);
        chk("live_before_dig", {3'b000, den4}, 7'b0001011);
        dig[2] = 4'h9;
        step();
        chk("live_after", disp4, 7'b0010000);
        chk("live_after_dig", {3'b000, den4}, 7'b0001011);

        // Mid-scan reset while digit 2 is shown; restart holds digit 0 for 4 cycles.
        step();
        rst = 1'b1;
        step();
        chk("midreset_dig", {3'b000, den4}, 7'b0001111);
        chk("midreset_disp", disp4, 7'b1111111);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("restart_pos0", {3'b000, den4}, 7'b0001110);
        end
        step();
        chk("restart_pos1", {3'b000, den4}, 7'b0001101);

        // Randomized run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 4; k++) dig[k] = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
